// File: rtl/safe_zone_map.sv
// rtl/safe_zone_map.sv - seeded LFSR safe-zone map generator with multi-port cell lookup
module safe_zone_map #(
  parameter int          SCREEN_WIDTH  = 800,
  parameter int          SCREEN_HEIGHT = 600,
  parameter int          BLOCK_SIZE    = 10,
  parameter int          NUM_PORTS     = 2,
  parameter int          RAND_WIDTH    = 8,
  parameter int          THR_NONE      = 64,
  parameter int          THR_ONE       = 128,
  parameter int          THR_TWO       = 192,
  parameter int          THR_ALL       = 64,
  parameter int          SPAWN_CX      = 40,
  parameter int          SPAWN_CY      = 30,
  parameter int          SPAWN_R       = 2,
  parameter logic [15:0] DEFAULT_SEED  = 16'hACE1
) (
  input  logic                                        clk,
  input  logic                                        arst_n,
  input  logic                                        i_regenerate_level,
  input  logic [15:0]                                 i_seed,
  output logic                                        o_rdy,
  output logic                                        o_done,
  input  logic [NUM_PORTS*$clog2(SCREEN_WIDTH)-1:0]   i_x,
  input  logic [NUM_PORTS*$clog2(SCREEN_HEIGHT)-1:0]  i_y,
  output logic [NUM_PORTS-1:0]                        o_is_safe,
  output logic [NUM_PORTS-1:0]                        o_valid
);
  localparam int COLS  = SCREEN_WIDTH / BLOCK_SIZE;
  localparam int ROWS  = SCREEN_HEIGHT / BLOCK_SIZE;
  localparam int CELLS = COLS * ROWS;
  localparam int XW    = $clog2(SCREEN_WIDTH);
  localparam int YW    = $clog2(SCREEN_HEIGHT);
  localparam int CXW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CYW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int THR_W = RAND_WIDTH + 1;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_FIN} state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [CXW-1:0]  cx;
  logic [CYW-1:0]  cy;
  logic            left_q;
  logic            diag_q;
  logic [COLS-1:0] line_buf;
  logic            map_mem [CELLS];

  logic                  up;
  logic                  cell_val;
  logic                  in_spawn;
  logic                  last_cell;
  logic                  gen_we;
  logic [THR_W-1:0]      thr;
  logic [RAND_WIDTH-1:0] rnd;
  logic [AW-1:0]         waddr;
  int                    dx;
  int                    dy;

  always_comb begin
    rnd       = lfsr[RAND_WIDTH-1:0];
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    up        = (cy != '0) && line_buf[cx];
    case ({up, left_q, diag_q})
      3'b111:  thr = THR_W'(THR_ALL);
      3'b110:  thr = THR_W'(THR_TWO);
      3'b000:  thr = THR_W'(THR_NONE);
      default: thr = THR_W'(THR_ONE);
    endcase
    dx = int'(cx) - SPAWN_CX;
    dy = int'(cy) - SPAWN_CY;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    in_spawn  = (dx <= SPAWN_R) && (dy <= SPAWN_R);
    cell_val  = in_spawn || ({1'b0, rnd} < thr);
    last_cell = (cx == CXW'(COLS - 1)) && (cy == CYW'(ROWS - 1));
    gen_we    = (state == S_GEN) && !i_regenerate_level;
    waddr     = AW'(int'(cy) * COLS + int'(cx));
  end

  // A request in any state restarts generation; it also suppresses the FIN done pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= S_IDLE;
      lfsr   <= DEFAULT_SEED;
      cx     <= '0;
      cy     <= '0;
      left_q <= 1'b0;
      diag_q <= 1'b0;
      o_rdy  <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_regenerate_level) begin
        state  <= S_GEN;
        lfsr   <= (i_seed == 16'h0000) ? DEFAULT_SEED : i_seed;
        cx     <= '0;
        cy     <= '0;
        left_q <= 1'b0;
        diag_q <= 1'b0;
        o_rdy  <= 1'b0;
      end else begin
        case (state)
          S_GEN: begin
            lfsr <= lfsr_next;
            if (cx == CXW'(COLS - 1)) begin
              cx     <= '0;
              cy     <= cy + CYW'(1);
              left_q <= 1'b0;
              diag_q <= 1'b0;
            end else begin
              cx     <= cx + CXW'(1);
              left_q <= cell_val;
              diag_q <= up;
            end
            if (last_cell) state <= S_FIN;
          end
          S_FIN: begin
            state  <= S_IDLE;
            o_done <= 1'b1;
            o_rdy  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // The line buffer slot for cx is overwritten only after its old value was latched into diag.
  always_ff @(posedge clk) begin
    if (gen_we) begin
      map_mem[waddr] <= cell_val;
      line_buf[cx]   <= cell_val;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [XW-1:0] qx;
    logic [YW-1:0] qy;
    logic          in_range;
    logic [AW-1:0] raddr;

    always_comb begin
      qx       = i_x[p*XW +: XW];
      qy       = i_y[p*YW +: YW];
      in_range = (int'(qx) < SCREEN_WIDTH) && (int'(qy) < SCREEN_HEIGHT);
      raddr    = AW'((int'(qy) / BLOCK_SIZE) * COLS + (int'(qx) / BLOCK_SIZE));
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        o_is_safe[p] <= 1'b0;
        o_valid[p]   <= 1'b0;
      end else if (o_rdy && !i_regenerate_level) begin
        o_is_safe[p] <= in_range ? map_mem[raddr] : 1'b0;
        o_valid[p]   <= 1'b1;
      end else begin
        o_is_safe[p] <= 1'b0;
        o_valid[p]   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_safe_zone_map.sv
// tb/tb_safe_zone_map.sv - directed bench for safe_zone_map (small 4x3 map and default 80x60 map)
module tb_safe_zone_map;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance: 40x30 pixels, 4x3 cells, spawn (1,1) radius 0
  logic        req_s = 1'b0;
  logic [15:0] seed_s = 16'h0;
  logic [11:0] x_s = '0;
  logic [9:0]  y_s = '0;
  logic        rdy_s, done_s;
  logic [1:0]  safe_s, valid_s;

  // default instance: 800x600 pixels
  logic        req_d = 1'b0;
  logic [15:0] seed_d = 16'h0;
  logic [19:0] x_d = '0;
  logic [19:0] y_d = '0;
  logic        rdy_d, done_d;
  logic [1:0]  safe_d, valid_d;

  safe_zone_map #(
    .SCREEN_WIDTH(40), .SCREEN_HEIGHT(30), .BLOCK_SIZE(10),
    .SPAWN_CX(1), .SPAWN_CY(1), .SPAWN_R(0)
  ) dut_s (
    .clk(clk), .arst_n(arst_n),
    .i_regenerate_level(req_s), .i_seed(seed_s),
    .o_rdy(rdy_s), .o_done(done_s),
    .i_x(x_s), .i_y(y_s),
    .o_is_safe(safe_s), .o_valid(valid_s)
  );

  safe_zone_map dut_d (
    .clk(clk), .arst_n(arst_n),
    .i_regenerate_level(req_d), .i_seed(seed_d),
    .o_rdy(rdy_d), .o_done(done_d),
    .i_x(x_d), .i_y(y_d),
    .o_is_safe(safe_d), .o_valid(valid_d)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: neighbours taken straight from the 2-D map, cell index = cy*4+cx.
  function automatic logic [11:0] model_map(input logic [15:0] seed);
    logic [15:0] l;
    logic [11:0] m;
    logic u, lf, dg, v;
    int thr;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    m = '0;
    for (int cy = 0; cy < 3; cy++) begin
      for (int cx = 0; cx < 4; cx++) begin
        u  = (cy > 0) ? m[(cy-1)*4 + cx] : 1'b0;
        lf = (cx > 0) ? m[cy*4 + cx - 1] : 1'b0;
        dg = (cy > 0 && cx > 0) ? m[(cy-1)*4 + cx - 1] : 1'b0;
        if (u && lf && dg)       thr = 64;
        else if (u && lf)        thr = 192;
        else if (!u && !lf && !dg) thr = 0 + 64;
        else                     thr = 128;
        v = (int'(l[7:0]) < thr);
        if (cx == 1 && cy == 1) v = 1'b1;
        m[cy*4 + cx] = v;
        l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
    end
    return m;
  endfunction

  // Issues a request on the small DUT; returns after the edge that sampled it.
  task automatic request_s(input logic [15:0] seed);
    req_s = 1'b1;
    seed_s = seed;
    tick();
    req_s = 1'b0;
  endtask

  task automatic wait_done_s(input int limit, output int cycles);
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (done_s) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic query_s(input int x0, input int y0, input int x1, input int y1);
    x_s = {6'(x1), 6'(x0)};
    y_s = {5'(y1), 5'(y0)};
    tick();
  endtask

  // Reads all 12 cells, two per cycle, hitting opposite corners of each block.
  task automatic read_map_s(output logic [11:0] m, output logic all_valid);
    all_valid = 1'b1;
    m = '0;
    for (int i = 0; i < 6; i++) begin
      query_s(((2*i) % 4) * 10, ((2*i) / 4) * 10 + 9, ((2*i+1) % 4) * 10 + 9, ((2*i+1) / 4) * 10);
      m[2*i]     = safe_s[0];
      m[2*i+1]   = safe_s[1];
      all_valid &= valid_s[0] & valid_s[1];
    end
  endtask

  initial begin
    int cyc;
    logic [11:0] m, m0;
    logic av, any_rdy, any_valid, any_done, any_safe;
    int bad_safe, bad_valid;

    // reset state
    repeat (3) tick();
    arst_n = 1'b1;
    any_rdy = 0; any_valid = 0; any_done = 0; any_safe = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      any_rdy   |= rdy_s | rdy_d;
      any_valid |= |valid_s | |valid_d;
      any_done  |= done_s | done_d;
      any_safe  |= |safe_s | |safe_d;
    end
    check("reset_rdy", any_rdy, 0);
    check("reset_valid", any_valid, 0);
    check("reset_done", any_done, 0);
    check("reset_is_safe", any_safe, 0);

    // generation with seed 1: hand-derived map rows 1111 / 0100 / 0011
    request_s(16'h0001);
    check("req_rdy_low", rdy_s, 0);
    wait_done_s(40, cyc);
    check("gen_len_seed1", cyc, 13);
    check("rdy_with_done", rdy_s, 1);
    tick();
    check("done_one_cycle", done_s, 0);
    read_map_s(m, av);
    check("map_seed1", m, 12'b1100_0010_1111);
    check("map_seed1_valid", av, 1);
    check("spawn_cell_1_1", m[5], 1);

    // multi-port and boundary queries
    query_s(15, 25, 39, 29);
    check("mp_safe", safe_s, 2'b10);
    check("mp_valid", valid_s, 2'b11);
    query_s(40, 0, 0, 30);
    check("oor_safe", safe_s, 2'b00);
    check("oor_valid", valid_s, 2'b11);
    query_s(39, 0, 10, 19);
    check("edge_safe", safe_s, 2'b11);

    // zero seed behaves as DEFAULT_SEED
    request_s(16'h0000);
    wait_done_s(40, cyc);
    check("gen_len_seed0", cyc, 13);
    read_map_s(m0, av);
    check("map_seed0", m0, model_map(16'hACE1));
    request_s(16'hACE1);
    wait_done_s(40, cyc);
    read_map_s(m, av);
    check("map_seedACE1", m, model_map(16'hACE1));
    check("seed0_eq_ACE1", m0, m);

    // restart five cycles into GEN
    request_s(16'h1234);
    repeat (5) tick();
    request_s(16'hBEEF);
    wait_done_s(40, cyc);
    check("restart_mid_len", cyc, 13);
    read_map_s(m, av);
    check("restart_mid_map", m, model_map(16'hBEEF));

    // restart coinciding with the last cell write
    request_s(16'h1234);
    repeat (11) tick();
    request_s(16'h0F0F);
    check("restart_last_done", done_s, 0);
    wait_done_s(40, cyc);
    check("restart_last_len", cyc, 13);
    read_map_s(m, av);
    check("restart_last_map", m, model_map(16'h0F0F));

    // request during FIN
    request_s(16'h1234);
    repeat (12) tick();
    request_s(16'h7777);
    check("restart_fin_done", done_s, 0);
    check("restart_fin_rdy", rdy_s, 0);
    wait_done_s(40, cyc);
    check("restart_fin_len", cyc, 13);
    read_map_s(m, av);
    check("restart_fin_map", m, model_map(16'h7777));

    // reset mid-GEN
    request_s(16'h00FF);
    repeat (3) tick();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    any_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_done |= done_s;
    end
    check("rst_mid_no_done", any_done, 0);
    check("rst_mid_rdy", rdy_s, 0);
    query_s(0, 0, 39, 29);
    check("rst_mid_valid", valid_s, 2'b00);

    // default-size map, spawn square pixels 380..429 x 280..329
    req_d = 1'b1;
    seed_d = 16'h5A5A;
    tick();
    req_d = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 6000; n++) begin
      tick();
      if (done_d) begin
        cyc = n;
        break;
      end
    end
    check("gen_len_default", cyc, 4801);
    check("rdy_default", rdy_d, 1);
    bad_safe = 0;
    bad_valid = 0;
    for (int y = 280; y < 330; y++) begin
      for (int x = 380; x < 430; x += 2) begin
        x_d = {10'(x + 1), 10'(x)};
        y_d = {10'(y), 10'(y)};
        tick();
        if (safe_d != 2'b11) bad_safe++;
        if (valid_d != 2'b11) bad_valid++;
      end
    end
    check("spawn_region_safe", bad_safe, 0);
    check("spawn_region_valid", bad_valid, 0);
    x_d = {10'd0, 10'd800};
    y_d = {10'd600, 10'd0};
    tick();
    check("default_oor_safe", safe_d, 2'b00);
    check("default_oor_valid", valid_d, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/safe_zone_map.md
# safe_zone_map

Parametrised level-map generator and multi-port lookup for the play-field safe zone. On request it fills a one-bit-per-cell map (1 = safe) of `(SCREEN_WIDTH/BLOCK_SIZE) x (SCREEN_HEIGHT/BLOCK_SIZE)` cells in raster order, one cell per clock. Each cell is drawn from a seeded LFSR with neighbour-dependent thresholds, and a forced-safe spawn square is overlaid. Once the map is ready, `NUM_PORTS` independent pixel-coordinate queries are answered with one-cycle registered latency, serving the renderer and the collision logic simultaneously.

## Interface
- `SCREEN_WIDTH`, 800: screen width in pixels.
- `SCREEN_HEIGHT`, 600: screen height in pixels.
- `BLOCK_SIZE`, 10: cell edge in pixels. Must divide both screen dimensions.
- `NUM_PORTS`, 2: number of query ports.
- `RAND_WIDTH`, 8: compared LFSR bits.
- `THR_NONE`, 64; `THR_ONE`, 128; `THR_TWO`, 192; `THR_ALL`, 64: safe thresholds out of `2**RAND_WIDTH`.
- `SPAWN_CX`, 40; `SPAWN_CY`, 30; `SPAWN_R`, 2: spawn centre cell and Chebyshev radius of the forced-safe square.
- `DEFAULT_SEED`, 16'hACE1: LFSR value after reset and for a zero seed.

Derived: `COLS = SCREEN_WIDTH/BLOCK_SIZE`, `ROWS = SCREEN_HEIGHT/BLOCK_SIZE`.

Ports:
- `clk` in 1: single clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `i_regenerate_level` in 1: one-cycle generation request.
- `i_seed` in 16: seed sampled with the request.
- `o_rdy` out 1: map valid and idle.
- `o_done` out 1: one-cycle pulse when generation completes.
- `i_x` in `NUM_PORTS x $clog2(SCREEN_WIDTH)`: query x, pixels, packed by port.
- `i_y` in `NUM_PORTS x $clog2(SCREEN_HEIGHT)`: query y, pixels.
- `o_is_safe` out `NUM_PORTS`: registered lookup result.
- `o_valid` out `NUM_PORTS`: registered result is meaningful.

## Operation
- **FSM states:**
  - IDLE → GEN on `i_regenerate_level`.
  - GEN → FIN after cell (`COLS-1`, `ROWS-1`) is written.
  - FIN → IDLE unconditionally.
- **Request acceptance:** `i_regenerate_level` in any state, including mid-GEN, restarts GEN at cell (0,0). The LFSR loads `i_seed`, or `DEFAULT_SEED` if `i_seed == 0`.
- **LFSR:** 16-bit Galois, taps `16'hB400`, shifting every GEN cycle. `rnd = lfsr[RAND_WIDTH-1:0]`.
- **Neighbours** of the current cell (`cx`, `cy`):
  - `up`: read from a `COLS`-bit line buffer holding the previous row.
  - `left`: a register.
  - `diag`: a register holding the previous column of the line buffer.
  - Any neighbour outside the map reads as 0.
- **Threshold selection:**
  - all three set → `THR_ALL`.
  - `up && left` (diag clear) → `THR_TWO`.
  - none set → `THR_NONE`.
  - otherwise → `THR_ONE`.
  - Cell value is `rnd < threshold`, compared at `RAND_WIDTH+1` bits.
- **Spawn override:** if `|cx-SPAWN_CX| <= SPAWN_R` and `|cy-SPAWN_CY| <= SPAWN_R`, the cell is forced to 1. The forced value also feeds the line buffer and `left`.
- **Write:** the value goes to map memory address `cy*COLS+cx`. `cx` wraps at `COLS-1`, which increments `cy` and clears `left`/`diag`.
- **Queries:**
  - Cell index is `(i_x/BLOCK_SIZE, i_y/BLOCK_SIZE)`.
  - Out-of-range coordinates (`i_x >= SCREEN_WIDTH` or `i_y >= SCREEN_HEIGHT`) return `o_is_safe = 0`, `o_valid = 1`.
  - While `o_rdy == 0`: `o_valid = 0` and `o_is_safe = 0`.
- **`o_rdy`:** 0 from reset until the first completed generation; 0 during GEN and FIN; 1 in IDLE once a map has completed.

## Timing
- **Reset values:** `o_rdy = 0`, `o_done = 0`, `o_is_safe = 0`, `o_valid = 0`. FSM is IDLE, LFSR is `DEFAULT_SEED`. Map contents are undefined.
- **Request cycle:** request seen at edge T; the first cell is written at edge T+1.
- **Generation length:** the last cell is written at edge T+`COLS*ROWS`. `o_done = 1` and `o_rdy = 1` after edge T+`COLS*ROWS`+1.
- **Query latency:** inputs sampled at edge N, result on `o_is_safe`/`o_valid` after edge N. This is a single registered stage per port; ports are fully independent.
- **Request during FIN:** the request wins; `o_done` is not pulsed.
- **Request in the same cycle as the last cell write:** restart; no `o_done`.
- **Request while idle:** `o_rdy` drops the cycle after the request.
- **Reset mid-GEN:** returns to IDLE with `o_rdy = 0`.

## Test plan
- **Reset state:** deassert `arst_n` with no request → `o_rdy = 0` and all `o_valid = 0` for 100 cycles.
- **Generation length and match:**
  - Setup: `SCREEN 40x30`, `BLOCK 10`, `SPAWN_R = 0`, `SPAWN (1,1)`; request with seed `16'h0001`.
  - Required: `o_done` exactly 13 cycles after the request.
  - Required: all 12 cells match a reference model using the same LFSR and thresholds.
  - Required: cell (1,1) = 1.
- **Zero seed:** request with `i_seed = 0` → map identical to the map produced with `i_seed = 16'hACE1`.
- **Multi-port query:**
  - Port0 `(15,25)`, port1 `(39,29)` in the same cycle → cells (1,2) and (3,2) after one edge, both `o_valid = 1`.
  - Port0 `(40,0)` → `o_is_safe = 0`, `o_valid = 1`.
- **Restart mid-GEN:** second request 5 cycles into GEN → no `o_done` at the original completion time. `o_done` arrives 13 cycles after the second request; the map matches a fresh run with the new seed.
- **Default-size spawn region:** request → `o_done` 4801 cycles later, and every pixel query inside x 380..429, y 280..329 returns 1.
